// File: rtl/branch_predict_unit.sv
// Branch predictor: direct-mapped BHT of 2-bit saturating counters plus a tagless BTB,
// with execute-stage resolution, mispredict flush/redirect and saturating statistics.
module branch_predict_unit #(
    parameter int WIDTH   = 16,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] if_pc,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_pc,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic [WIDTH-1:0] ex_target,
    input  logic             ex_zero,
    input  logic             ex_ltz,
    input  logic [1:0]       ex_branch_op,
    input  logic             ex_pred_taken,
    input  logic [WIDTH-1:0] ex_pred_pc,
    output logic             flush,
    output logic [WIDTH-1:0] redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam int IDX_W = $clog2(ENTRIES);

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        OP_EQZ = 2'b00,
        OP_NEZ = 2'b01,
        OP_LTZ = 2'b10,
        OP_GEZ = 2'b11
    } branch_op_e;

    localparam logic [1:0] CTR_RESET = 2'b01;

    logic [1:0]       ctr [ENTRIES];
    logic [WIDTH-1:0] tgt [ENTRIES];
    logic [ENTRIES-1:0] v;

    idx_t             if_idx;
    idx_t             ex_idx;
    logic [WIDTH-1:0] if_seq;
    logic [WIDTH-1:0] ex_seq;
    logic             cond;
    logic             act;
    logic             upd;
    logic [WIDTH-1:0] correct;

    // Bit 0 is dropped: instructions are halfword aligned.
    assign if_idx = if_pc[IDX_W:1];
    assign ex_idx = ex_pc[IDX_W:1];
    assign if_seq = if_pc + WIDTH'(2);
    assign ex_seq = ex_pc + WIDTH'(2);

    // Fetch lookup reads pre-update state; a same-cycle update is not bypassed.
    assign pred_taken = v[if_idx] & ctr[if_idx][1];
    assign pred_pc    = pred_taken ? tgt[if_idx] : if_seq;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cond = 1'b0;
        case (branch_op_e'(ex_branch_op))
            OP_EQZ:  cond = ex_zero;
            OP_NEZ:  cond = ~ex_zero;
            OP_LTZ:  cond = ex_ltz;
            OP_GEZ:  cond = ~ex_ltz;
            default: cond = 1'b0;
        endcase
    end

    assign act         = ex_valid & cond;
    assign upd         = ex_valid & ~ex_stall;
    assign correct     = act ? ex_target : ex_seq;
    assign flush       = upd & ((act != ex_pred_taken) | (act & (ex_pred_pc != ex_target)));
    assign redirect_pc = correct;

    // NOTE: the tables are small register arrays that must come out of reset in a known
    // state, so every entry is cleared by the async reset rather than left as RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= CTR_RESET;
                tgt[i] <= '0;
            end
            v <= '0;
        end else if (upd) begin
            if (act) begin
                if (ctr[ex_idx] != 2'b11) begin
                    ctr[ex_idx] <= ctr[ex_idx] + 2'd1;
                end
                tgt[ex_idx] <= ex_target;
                v[ex_idx]   <= 1'b1;
            end else if (ctr[ex_idx] != 2'b00) begin
                ctr[ex_idx] <= ctr[ex_idx] - 2'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count <= '0;
            mp_count <= '0;
        end else if (upd) begin
            if (br_count != '1) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (flush && (mp_count != '1)) begin
                mp_count <= mp_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: a small reference model pushes expected
// values onto a scoreboard queue that is drained against DUT outputs.
module tb_branch_predict_unit;

    localparam int WIDTH   = 16;
    localparam int ENTRIES = 16;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] if_pc = '0;
    logic             pred_taken;
    logic [WIDTH-1:0] pred_pc;
    logic             ex_valid = 1'b0;
    logic             ex_stall = 1'b0;
    logic [WIDTH-1:0] ex_pc = '0;
    logic [WIDTH-1:0] ex_target = '0;
    logic             ex_zero = 1'b0;
    logic             ex_ltz = 1'b0;
    logic [1:0]       ex_branch_op = 2'b00;
    logic             ex_pred_taken = 1'b0;
    logic [WIDTH-1:0] ex_pred_pc = '0;
    logic             flush;
    logic [WIDTH-1:0] redirect_pc;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mp_count;

    branch_predict_unit #(.WIDTH(WIDTH), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_zero(ex_zero), .ex_ltz(ex_ltz), .ex_branch_op(ex_branch_op),
        .ex_pred_taken(ex_pred_taken), .ex_pred_pc(ex_pred_pc), .flush(flush),
        .redirect_pc(redirect_pc), .br_count(br_count), .mp_count(mp_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Independent reference state.
    int          m_ctr [ENTRIES];
    logic [15:0] m_tgt [ENTRIES];
    bit          m_v   [ENTRIES];
    int          m_br;
    int          m_mp;

    function automatic int idx_of(input logic [15:0] pc);
        return int'(pc / 2) % ENTRIES;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_ctr[i] = 1;
            m_tgt[i] = 16'h0000;
            m_v[i]   = 1'b0;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic lookup(input logic [15:0] pc);
        bit          tk;
        logic [15:0] npc;
        @(negedge clk);
        if_pc = pc;
        tk  = m_v[idx_of(pc)] && (m_ctr[idx_of(pc)] >= 2);
        npc = tk ? m_tgt[idx_of(pc)] : 16'(pc + 16'd2);
        push($sformatf("pred_taken@%h", pc), {31'b0, tk});
        push($sformatf("pred_pc@%h", pc), {16'b0, npc});
        #1;
        check({31'b0, pred_taken});
        check({16'b0, pred_pc});
    endtask

    task automatic resolve(input logic [15:0] pc, input logic [15:0] target, input logic [1:0] op,
                           input bit zero, input bit ltz, input bit pt, input logic [15:0] ppc,
                           input bit stall);
        bit          cond;
        bit          fl;
        logic [15:0] corr;
        int          j;
        @(negedge clk);
        ex_valid = 1'b1; ex_stall = stall; ex_pc = pc; ex_target = target;
        ex_branch_op = op; ex_zero = zero; ex_ltz = ltz;
        ex_pred_taken = pt; ex_pred_pc = ppc;
        case (op)
            2'b00: cond = zero;
            2'b01: cond = !zero;
            2'b10: cond = ltz;
            default: cond = !ltz;
        endcase
        corr = cond ? target : 16'(pc + 16'd2);
        fl   = !stall && ((cond != pt) || (cond && ppc != target));
        push($sformatf("flush@%h", pc), {31'b0, fl});
        push($sformatf("redirect@%h", pc), {16'b0, corr});
        #1;
        check({31'b0, flush});
        check({16'b0, redirect_pc});
        @(posedge clk);
        if (!stall) begin
            j = idx_of(pc);
            if (cond) begin
                if (m_ctr[j] < 3) m_ctr[j]++;
                m_tgt[j] = target;
                m_v[j]   = 1'b1;
            end else if (m_ctr[j] > 0) begin
                m_ctr[j]--;
            end
            m_br++;
            if (fl) m_mp++;
        end
        #1;
        ex_valid = 1'b0; ex_stall = 1'b0;
        push("br_count", 32'(m_br));
        push("mp_count", 32'(m_mp));
        check(32'(br_count));
        check(32'(mp_count));
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset state and first lookup.
        lookup(16'h0010);
        push("reset_br", 32'd0);
        check(32'(br_count));
        push("reset_mp", 32'd0);
        check(32'(mp_count));

        // First taken resolve mispredicts, then trains the entry.
        resolve(16'h0010, 16'h0040, 2'b00, 1, 0, 0, 16'h0012, 0);
        lookup(16'h0010);

        // Saturate taken, then two not-taken resolves.
        repeat (3) resolve(16'h0010, 16'h0040, 2'b00, 1, 0, 1, 16'h0040, 0);
        resolve(16'h0010, 16'h0040, 2'b01, 1, 0, 1, 16'h0040, 0);
        lookup(16'h0010);
        resolve(16'h0010, 16'h0040, 2'b01, 1, 0, 1, 16'h0040, 0);
        lookup(16'h0010);

        // Retrain, then right direction but wrong target.
        resolve(16'h0010, 16'h0040, 2'b00, 1, 0, 0, 16'h0012, 0);
        resolve(16'h0010, 16'h0080, 2'b00, 1, 0, 1, 16'h0040, 0);
        lookup(16'h0010);

        // Stall hides a mispredict; the re-presented branch then flushes.
        resolve(16'h0010, 16'h0080, 2'b00, 0, 0, 1, 16'h0080, 1);
        lookup(16'h0010);
        resolve(16'h0010, 16'h0080, 2'b00, 0, 0, 1, 16'h0080, 0);

        // Aliasing: 0x0030 shares index 8 with 0x0010.
        resolve(16'h0010, 16'h0080, 2'b00, 1, 0, 0, 16'h0012, 0);
        lookup(16'h0030);

        // ltz / gez conditions and top-of-address-space wrap.
        resolve(16'h0100, 16'h0200, 2'b10, 0, 1, 0, 16'h0102, 0);
        resolve(16'h0100, 16'h0200, 2'b11, 0, 1, 0, 16'h0102, 0);
        resolve(16'h0104, 16'h0300, 2'b11, 0, 0, 1, 16'h0300, 0);
        lookup(16'hFFFE);
        resolve(16'hFFFE, 16'h1000, 2'b01, 1, 0, 0, 16'h0000, 0);

        // Asynchronous reset pulse mid-cycle clears everything.
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        push("async_br", 32'd0);
        check(32'(br_count));
        push("async_mp", 32'd0);
        check(32'(mp_count));
        @(posedge clk);
        #2 rst_n = 1'b1;
        lookup(16'h0010);
        lookup(16'h0100);

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the single-cycle branch PC select. Adds a direct-mapped branch history table (BHT) of 2-bit saturating counters and a tagless branch target buffer (BTB).
- Fetch side: lookup that predicts the next PC.
- Execute side: resolves the branch condition, detects mispredicts and produces the redirect PC, then updates the tables on the clock edge.
- Also keeps saturating branch and mispredict statistics counters.

Parameters:
- WIDTH, 16, PC/address width in bits.
- ENTRIES, 16, BHT/BTB entry count. Power of two, range 2..256.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_pc  in  WIDTH  fetch PC.
- pred_taken  out  1  fetch prediction: taken.
- pred_pc  out  WIDTH  predicted next fetch PC.
- ex_valid  in  1  a branch instruction is resolving in EX this cycle.
- ex_stall  in  1  EX is held. Suppresses all updates and the flush.
- ex_pc  in  WIDTH  PC of the resolving branch.
- ex_target  in  WIDTH  computed branch target.
- ex_zero  in  1  ALU zero flag.
- ex_ltz  in  1  ALU less-than-zero flag.
- ex_branch_op  in  2  00 = eq-zero, 01 = ne-zero, 10 = ltz, 11 = gez.
- ex_pred_taken  in  1  prediction carried down the pipe with this branch.
- ex_pred_pc  in  WIDTH  predicted PC carried down the pipe.
- flush  out  1  mispredict: squash younger instructions and redirect fetch.
- redirect_pc  out  WIDTH  correct next PC.
- br_count  out  CNT_W  branches resolved.
- mp_count  out  CNT_W  mispredicts.

Behaviour:
- Index: idx = pc[log2(ENTRIES):1]. Bit 0 is ignored because instructions are 2-byte aligned.
- State per entry:
  - ctr[1:0]; reset value 01 (weakly not-taken).
  - tgt[WIDTH-1:0]; reset value 0.
  - v; reset value 0.
- Fetch lookup is combinational from the current state:
  - pred_taken = v[i] & ctr[i][1].
  - pred_pc = pred_taken ? tgt[i] : if_pc + 2, modulo 2^WIDTH (wraps at the top of the address space).
- Condition cond selected by ex_branch_op: zero, ~zero, ltz, ~ltz.
- act = ex_valid & cond.
- upd = ex_valid & ~ex_stall.
- correct = act ? ex_target : ex_pc + 2.
- flush (combinational) = upd & ((act != ex_pred_taken) | (act & (ex_pred_pc != ex_target))).
- redirect_pc = correct whenever ex_valid; otherwise ex_pc + 2. Consumers use redirect_pc only when flush = 1.
- On each rising edge with upd = 1, entry j = idx(ex_pc) is updated:
  - act = 1: ctr[j] increments, saturating at 11; tgt[j] <= ex_target; v[j] <= 1.
  - act = 0: ctr[j] decrements, saturating at 00; tgt and v are unchanged.
  - br_count increments, saturating at all-ones.
  - mp_count increments if flush = 1, saturating at all-ones.
- ex_stall = 1: no state changes and flush = 0, even when a mispredict condition exists. The branch re-presents on a later cycle.
- Same-cycle lookup and update of the same index: the lookup sees the pre-update value; there is no bypass. The update is visible to a lookup on the next cycle.
- Aliasing: distinct PCs sharing an index share an entry. This is intended; there is no tag.
- Reset: async assertion immediately forces all ctr = 01, v = 0, tgt = 0, br_count = 0, mp_count = 0.
  - Outputs after reset: pred_taken = 0, pred_pc = if_pc + 2.
  - A reset mid-update wins; no partial entry write occurs.
  - Deassertion is assumed synchronised externally.
- Latency: prediction 0 cycles (combinational); flush 0 cycles; table update visible 1 cycle after resolve.

Test Plan:
1. Reset → lookup if_pc = 0x0010 → pred_taken = 0, pred_pc = 0x0012; br_count = mp_count = 0.
2. Resolve ex_pc = 0x0010, op = 00, zero = 1, ex_pred_taken = 0, target = 0x0040 → flush = 1, redirect_pc = 0x0040. Next cycle: ctr = 10, v = 1, lookup 0x0010 gives pred_taken = 1, pred_pc = 0x0040; mp_count = 1.
3. Resolve the same branch taken 3 more times → ctr saturates at 11. Then resolve not-taken twice (op = 01, zero = 1) → ctr goes 11→10→01. First not-taken resolve: flush = 1, redirect_pc = 0x0012.
4. Correct prediction but wrong target (ex_pred_pc = 0x0040, ex_target = 0x0080, taken) → flush = 1, redirect_pc = 0x0080, tgt updated to 0x0080.
5. ex_stall = 1 with a mispredicting branch → flush = 0, no counter or table change. Deassert stall → flush = 1 and update occurs.
6. Aliasing, ENTRIES = 16: 0x0010 and 0x0030 share index 8; training 0x0010 taken makes 0x0030 predict taken. Also verify if_pc = 0xFFFE not-taken gives pred_pc = 0x0000, and that an async rst_n pulse mid-run clears all state.
